// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcodes, ALU codes and operand selects for multicycle_control
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_FETCH_WAIT, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
    S_MEM_WAIT, S_LD_WB, S_MEM_WRITE, S_BRANCH, S_PC_INC, S_HALT
  } state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LD, C_SD, C_BR, C_ILL} iclass_t;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_IMM2 = 2'd3;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction class, ALU function and illegal-instruction decode
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instruction,
  output iclass_t     iclass,
  output logic [2:0]  alu_op,
  output logic        illegal
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic       unused_bits;
  assign opc = instruction[6:0];
  assign f3 = instruction[14:12];
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};
  always_comb begin
    iclass = opc == OP_R ? C_R : opc == OP_I ? C_I : opc == OP_LD ? C_LD :
             opc == OP_SD ? C_SD : opc == OP_BR ? C_BR : C_ILL;
    alu_op = f3 == 3'b000 ? ((iclass == C_R && instruction[30]) ? ALU_SUB : ALU_ADD) :
             f3 == 3'b111 ? ALU_AND : f3 == 3'b100 ? ALU_XOR : ALU_NOP;
    illegal = iclass == C_ILL || ((iclass == C_R || iclass == C_I) && alu_op == ALU_NOP);
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore multicycle RISC-V control FSM; CTRL_TRAP_EN makes illegal instructions halt
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        LoadAOut,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        LoadMDR,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        DMemOp,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        halted
);
`ifdef CTRL_TRAP_EN
  localparam state_t ILL_NEXT = S_HALT;
`else
  localparam state_t ILL_NEXT = S_PC_INC;
`endif
  state_t     state, state_nxt;
  iclass_t    iclass;
  logic [2:0] dec_op;
  logic       illegal;
  ctrl_decode u_dec (
    .instruction(instruction),
    .iclass     (iclass),
    .alu_op     (dec_op),
    .illegal    (illegal)
  );
  always_ff @(posedge clk) state <= reset ? S_RESET : state_nxt;
  always_comb begin
    state_nxt = state;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    PCSource = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_REG;
    ALUOp = ALU_NOP;
    LoadAOut = 1'b0;
    LoadRegA = 1'b0;
    LoadRegB = 1'b0;
    LoadMDR = 1'b0;
    RegWrite = 1'b0;
    MemToReg = 1'b0;
    DMemOp = 1'b0;
    IMemRead = 1'b0;
    IRWrite = 1'b0;
    halted = 1'b0;
    case (state)
      S_RESET: state_nxt = S_FETCH;
      S_FETCH: begin
        IMemRead = 1'b1;
        state_nxt = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        IMemRead = 1'b1;
        IRWrite = 1'b1;
        LoadAOut = 1'b1;
        ALUSrcB = SRCB_IMM2;
        ALUOp = ALU_ADD;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        LoadRegA = 1'b1;
        LoadRegB = 1'b1;
        state_nxt = illegal ? ILL_NEXT : iclass == C_R ? S_EXEC_R : iclass == C_I ? S_EXEC_I :
                    iclass == C_LD ? S_MEM_ADDR : iclass == C_SD ? S_MEM_WRITE : S_BRANCH;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = dec_op;
        RegWrite = 1'b1;
        state_nxt = S_PC_INC;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = dec_op;
        RegWrite = 1'b1;
        state_nxt = S_PC_INC;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD;
        state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD;
        LoadMDR = 1'b1;
        state_nxt = S_LD_WB;
      end
      S_LD_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUOp = ALU_ADD;
        PCWrite = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEM_WRITE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp = ALU_ADD;
        DMemOp = 1'b1;
        state_nxt = S_PC_INC;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource = 1'b1;
        state_nxt = alu_zero ? S_FETCH : S_PC_INC;
      end
      S_PC_INC: begin
        ALUSrcB = SRCB_FOUR;
        ALUOp = ALU_ADD;
        PCWrite = 1'b1;
        state_nxt = S_FETCH;
      end
`ifdef CTRL_TRAP_EN
      S_HALT: halted = 1'b1;
`endif
      default: state_nxt = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instructions checked each cycle against a per-instruction output-sequence model
module tb_multicycle_control;
  typedef struct packed {
    logic pcw, pcwc, pcs, srca;
    logic [1:0] srcb;
    logic [2:0] op;
    logic la, lra, lrb, lmdr, rw, m2r, dm, imr, irw, hlt;
  } ctl_t;
  logic clk = 1'b0, reset, alu_zero;
  logic [31:0] instruction;
  logic PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, LoadRegA, LoadRegB, LoadMDR;
  logic RegWrite, MemToReg, DMemOp, IMemRead, IRWrite, halted;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  ctl_t act, e_cur;
  ctl_t seq[$];
  ctl_t exp_q[$];
  int pass_n = 0, total_n = 0;
  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .LoadAOut(LoadAOut), .LoadRegA(LoadRegA),
    .LoadRegB(LoadRegB), .LoadMDR(LoadMDR), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .DMemOp(DMemOp), .IMemRead(IMemRead), .IRWrite(IRWrite), .halted(halted)
  );
  assign act = {PCWrite, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut, LoadRegA,
                LoadRegB, LoadMDR, RegWrite, MemToReg, DMemOp, IMemRead, IRWrite, halted};
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
  endtask
  always @(negedge clk)
    if (exp_q.size() != 0) begin
      e_cur = exp_q.pop_front();
      check("ctl", act, e_cur);
    end
  task automatic build(input logic [31:0] ins);
    ctl_t c;
    logic [6:0] opc;
    logic [2:0] f3, aop;
    bit r, i, ill;
    opc = ins[6:0];
    f3 = ins[14:12];
    r = opc == 7'b0110011;
    i = opc == 7'b0010011;
    aop = f3 == 3'd0 ? ((r && ins[30]) ? 3'b010 : 3'b001) : f3 == 3'd7 ? 3'b011 :
          f3 == 3'd4 ? 3'b110 : 3'b000;
    ill = !(r || i || opc == 7'b0000011 || opc == 7'b0100011 || opc == 7'b1100011) ||
          ((r || i) && aop == 3'b000);
    seq.delete();
    c = '0; c.imr = 1; seq.push_back(c);
    c = '0; c.imr = 1; c.irw = 1; c.la = 1; c.srcb = 3; c.op = 3'b001; seq.push_back(c);
    c = '0; c.lra = 1; c.lrb = 1; seq.push_back(c);
    c = '0;
    if (ill) begin
`ifdef CTRL_TRAP_EN
      c.hlt = 1;
      repeat (20) seq.push_back(c);
      return;
`endif
    end else if (r) begin
      c.srca = 1; c.op = aop; c.rw = 1; seq.push_back(c);
    end else if (i) begin
      c.srca = 1; c.srcb = 2; c.op = aop; c.rw = 1; seq.push_back(c);
    end else if (opc == 7'b0000011) begin
      c.srca = 1; c.srcb = 2; c.op = 3'b001; seq.push_back(c);
      c.lmdr = 1; seq.push_back(c);
      c = '0; c.rw = 1; c.m2r = 1; c.srcb = 1; c.op = 3'b001; c.pcw = 1; seq.push_back(c);
      return;
    end else if (opc == 7'b0100011) begin
      c.srca = 1; c.srcb = 2; c.op = 3'b001; c.dm = 1; seq.push_back(c);
    end else begin
      c.srca = 1; c.op = 3'b010; c.pcwc = 1; c.pcs = 1; seq.push_back(c);
      if (alu_zero) return;
    end
    c = '0; c.srcb = 1; c.op = 3'b001; c.pcw = 1; seq.push_back(c);
  endtask
  task automatic run(input logic [31:0] ins, input bit az, input int keep);
    int n;
    instruction = ins;
    alu_zero = az;
    build(ins);
    n = keep != 0 ? keep : seq.size();
    for (int k = 0; k < n; k++) exp_q.push_back(seq[k]);
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
    if (keep != 0) reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic release_rst(input int hold);
    ctl_t z = '0;
    repeat (hold) begin
      exp_q.push_back(z);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    exp_q.push_back(z);
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    instruction = '0;
    alu_zero = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out", act, 0);
    check("rst_halted", halted, 0);
    release_rst(1);
    run(32'h002081B3, 0, 0);
    check("add_len", seq.size(), 5);
    check("add_exec", {seq[3].op, seq[3].rw}, 4'b0011);
    check("add_pcinc", seq[4].pcw, 1);
    run(32'h402081B3, 1, 0);
    check("sub_op", seq[3].op, 3'b010);
    run(32'h0080B183, 1, 0);
    check("ld_len", seq.size(), 6);
    check("ld_mdr", seq[4].lmdr, 1);
    check("ld_wb", {seq[5].rw, seq[5].m2r, seq[5].pcw}, 3'b111);
    run(32'h0020B423, 1, 0);
    check("sd_len", seq.size(), 5);
    check("sd_dm", {seq[3].dm, seq[3].rw}, 2'b10);
    run(32'h00208863, 1, 0);
    check("beq_t_len", seq.size(), 4);
    check("beq_t", {seq[3].pcwc, seq[3].pcs}, 2'b11);
    run(32'h00208863, 0, 0);
    check("beq_nt_len", seq.size(), 5);
    run(32'h0050F193, 0, 0);
    check("andi_op", seq[3].op, 3'b011);
    run(32'h0050C193, 1, 0);
    run(32'h0020C1B3, 0, 0);
    check("xor_op", seq[3].op, 3'b110);
    run(32'h0080B183, 0, 5);
    release_rst(0);
    run(32'h002081B3, 1, 0);
`ifdef CTRL_TRAP_EN
    run(32'hFFFFFFFF, 0, 23);
    check("trap_h", {seq[2].hlt, seq[3].hlt}, 2'b01);
    release_rst(0);
    run(32'h002091B3, 1, 23);
    release_rst(0);
`else
    run(32'hFFFFFFFF, 0, 0);
    check("nop_len", {seq[3].pcw, seq[3].hlt}, 2'b10);
    run(32'h002091B3, 1, 0);
`endif
    run(32'h0020B423, 0, 0);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
